fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencing controller for the PC/next-PC datapath. It generates the five PC mux selects each cycle from fetch-handshake and redirect events, so that pc_next is sequential, held, branch, jal or jalr.
It also runs the instruction-memory request handshake, a post-reset wait, a one-bubble redirect flush and a fetch-timeout watchdog.
It sits between decode/execute (redirect and stall sources), instruction memory and the PC datapath.

Parameters:
RST_WAIT, 2, cycles after rst deasserts before the first imem_req (≥1)
TIMEOUT, 255, consecutive un-acked FETCH cycles before fetch_err is raised (≥1)
CNT_W, 8, width of the shared wait/watchdog counter (must hold max(RST_WAIT, TIMEOUT))

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
imem_ack  in  1  instruction for the current pc is valid this cycle
stall  in  1  decode cannot accept; hold pc
br_taken  in  1  conditional branch resolved taken; target on brch_address
jal  in  1  jump to the absolute imm_20 target
jalr  in  1  jump to reg_in + imm_12
imem_req  out  1  fetch request at current pc, registered
inst_valid  out  1  fetched instruction may be consumed, combinational
flush  out  1  squash the younger instruction in decode, registered
fetch_err  out  1  sticky watchdog error, registered
mux1  out  1  1: adder result, 0: brch_address
mux2  out  1  1: hold pc, 0: take mux3 path
mux3  out  1  1: imm_20, 0: mux1 path
mux4  out  1  1: constant 4, 0: imm_12 (adder operand A)
mux4_2  out  1  1: pc, 0: reg_in (adder operand B)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Select encodings (combinational from state and inputs; pc_next is valid in the same cycle):
  - SEQ: mux2=0, mux3=0, mux1=1, mux4=1, mux4_2=1, giving pc+4.
  - HOLD: mux2=1, other selects at their SEQ values.
  - BR: mux2=0, mux3=0, mux1=0; mux4 and mux4_2 at SEQ values.
  - JAL: mux2=0, mux3=1; others at SEQ values.
  - JALR: mux2=0, mux3=0, mux1=1, mux4=0, mux4_2=0.
- Redirect = jalr | jal | br_taken. Priority is jalr > jal > br_taken.
- Reset:
  - rst=1 forces state IDLE and cnt=0.
  - imem_req, flush and fetch_err reset to 0.
  - inst_valid is 0 and the selects are HOLD while rst=1 (combinational override).
- FSM states: IDLE, FETCH, BUBBLE, ERR.
- IDLE:
  - Selects HOLD, imem_req=0, inputs ignored.
  - cnt increments each cycle; at cnt==RST_WAIT-1, go to FETCH and set cnt=0.
- FETCH (imem_req=1), evaluated in this priority order:
  - Redirect: selects per priority; inst_valid=0; next cycle flush=1, imem_req=0, state BUBBLE; cnt=0. Redirect wins over stall and over ack.
  - imem_ack & !stall: SEQ, inst_valid=1, cnt=0.
  - imem_ack & stall: HOLD, inst_valid=1 (decode ignores it); the same pc is re-fetched; cnt=0.
  - No ack: HOLD, inst_valid=0, cnt+1. When cnt reaches TIMEOUT-1 (i.e. TIMEOUT un-acked cycles), go to ERR.
- BUBBLE (one cycle, flush=1, imem_req=0):
  - Selects HOLD, then return to FETCH.
  - A new redirect in BUBBLE is accepted (selects per priority) and the controller stays in BUBBLE one more cycle with flush=1.
- ERR:
  - fetch_err=1, imem_req=0, selects HOLD, inst_valid=0.
  - Left only by rst.
- Counter saturates; it never wraps.
- Redirect penalty is exactly 1 bubble cycle.
- Reset asserted mid-fetch or mid-bubble drops all activity at that edge.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, BUBBLE, ERR);
  - a 5-bit select-vector typedef {mux1, mux2, mux3, mux4, mux4_2};
  - constants SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JAL, SEL_JALR.
- No sub-module; the single saturating counter stays inline.

Test Plan:
- Reset release with RST_WAIT=2: imem_req rises on the 3rd cycle after rst falls. Selects stay HOLD before that (mux2=1), so pc holds 0 through the wait.
- Steady fetch, imem_ack=1 for 4 cycles with no stall: SEQ every cycle, inst_valid=1, pc 0→4→8→12→16.
- stall=1 for 2 cycles during ack: mux2=1 and pc holds at 8, then resumes 8→12 when stall drops.
- Redirect ordering:
  - br_taken with brch_address=0x100: mux1=0, pc=0x100; next cycle flush=1, imem_req=0; the cycle after, fetch at 0x100.
  - jal and jalr together: JALR selects win (mux4=0, mux4_2=0).
- No ack with TIMEOUT=4: after 4 un-acked FETCH cycles, fetch_err=1 and imem_req=0 sticky until rst; a later imem_ack has no effect.
- rst asserted in BUBBLE: the next cycle is IDLE with flush=0 and fetch_err=0; the full RST_WAIT is repeated.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
//   state_e : controller states
//   sel_t   : PC mux select vector {mux1, mux2, mux3, mux4, mux4_2}
//   SEL_*   : select patterns for each pc_next source
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        BUBBLE = 2'd2,
        ERR    = 2'd3
    } state_e;

    typedef struct packed {
        logic mux1;    // 1: adder result, 0: brch_address
        logic mux2;    // 1: hold pc, 0: mux3 path
        logic mux3;    // 1: imm_20, 0: mux1 path
        logic mux4;    // 1: constant 4, 0: imm_12
        logic mux4_2;  // 1: pc, 0: reg_in
    } sel_t;

    localparam sel_t SEL_SEQ  = '{mux1: 1'b1, mux2: 1'b0, mux3: 1'b0, mux4: 1'b1, mux4_2: 1'b1};
    localparam sel_t SEL_HOLD = '{mux1: 1'b1, mux2: 1'b1, mux3: 1'b0, mux4: 1'b1, mux4_2: 1'b1};
    localparam sel_t SEL_BR   = '{mux1: 1'b0, mux2: 1'b0, mux3: 1'b0, mux4: 1'b1, mux4_2: 1'b1};
    localparam sel_t SEL_JAL  = '{mux1: 1'b1, mux2: 1'b0, mux3: 1'b1, mux4: 1'b1, mux4_2: 1'b1};
    localparam sel_t SEL_JALR = '{mux1: 1'b1, mux2: 1'b0, mux3: 1'b0, mux4: 1'b0, mux4_2: 1'b0};

    // Redirect source priority: jalr > jal > br_taken.
    function automatic sel_t redirect_sel(input logic jalr_i, input logic jal_i);
        sel_t s;
        if (jalr_i) begin
            s = SEL_JALR;
        end else if (jal_i) begin
            s = SEL_JAL;
        end else begin
            s = SEL_BR;
        end
        return s;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller for the PC/next-PC datapath.
// Drives the five PC mux selects, the imem request handshake, a post-reset
// wait, a one-cycle redirect flush and a sticky fetch-timeout watchdog.
//   clk, rst                 : clock, synchronous active-high reset
//   imem_ack                 : instruction for current pc valid
//   stall                    : decode cannot accept, hold pc
//   br_taken, jal, jalr      : redirect sources (jalr > jal > br_taken)
//   imem_req                 : fetch request (registered)
//   inst_valid               : fetched instruction consumable (combinational)
//   flush                    : squash younger instruction (registered)
//   fetch_err                : sticky watchdog error (registered)
//   mux1..mux4_2             : PC mux selects (combinational)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned RST_WAIT = 2,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic imem_ack,
    input  logic stall,
    input  logic br_taken,
    input  logic jal,
    input  logic jalr,
    output logic imem_req,
    output logic inst_valid,
    output logic flush,
    output logic fetch_err,
    output logic mux1,
    output logic mux2,
    output logic mux3,
    output logic mux4,
    output logic mux4_2
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(RST_WAIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             imem_req_q, flush_q, fetch_err_q;
    logic             redirect;
    sel_t             sel;
    sel_t             redir_sel;

    assign redirect  = jalr | jal | br_taken;
    assign redir_sel = redirect_sel(jalr, jal);
    // Shared wait/watchdog counter saturates instead of wrapping.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            imem_req_q  <= 1'b0;
            flush_q     <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            imem_req_q  <= (state_d == FETCH);
            flush_q     <= (state_d == BUBBLE);
            fetch_err_q <= (state_d == ERR);
        end
    end

    // Next state, counter and combinational selects.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel        = SEL_HOLD;
        inst_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FETCH: begin
                if (redirect) begin
                    sel     = redir_sel;
                    state_d = BUBBLE;
                    cnt_d   = '0;
                end else if (imem_ack) begin
                    // Ack under stall still flags valid; the same pc is re-fetched.
                    inst_valid = 1'b1;
                    sel        = stall ? SEL_HOLD : SEL_SEQ;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ERR;
                    end
                end
            end
            BUBBLE: begin
                cnt_d = '0;
                // A fresh redirect restarts the bubble rather than resuming fetch.
                if (redirect) begin
                    sel = redir_sel;
                end else begin
                    state_d = FETCH;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            sel        = SEL_HOLD;
            inst_valid = 1'b0;
        end
    end

    assign imem_req  = imem_req_q;
    assign flush     = flush_q;
    assign fetch_err = fetch_err_q;
    assign mux1      = sel.mux1;
    assign mux2      = sel.mux2;
    assign mux3      = sel.mux3;
    assign mux4      = sel.mux4;
    assign mux4_2    = sel.mux4_2;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural PC datapath and an
// event-level reference model of the fetch sequence.
module tb_fetch_ctrl;

    localparam int unsigned RST_WAIT = 2;
    localparam int unsigned TIMEOUT  = 4;

    // {mux1, mux2, mux3, mux4, mux4_2}
    localparam logic [4:0] B_SEQ  = 5'b10011;
    localparam logic [4:0] B_HOLD = 5'b11011;
    localparam logic [4:0] B_BR   = 5'b00011;
    localparam logic [4:0] B_JAL  = 5'b10111;
    localparam logic [4:0] B_JALR = 5'b10000;

    logic clk = 1'b0;
    logic rst, imem_ack, stall, br_taken, jal, jalr;
    logic imem_req, inst_valid, flush, fetch_err;
    logic mux1, mux2, mux3, mux4, mux4_2;

    logic [31:0] pc, pc_next, add_res, brch, imm20, imm12, reg_in;

    int total = 0;
    int bad   = 0;

    // Reference model: position in the fetch sequence expressed as flags/counts.
    bit          m_waiting = 1'b1;
    int          m_elapsed = 0;
    bit          m_bubble  = 1'b0;
    bit          m_err     = 1'b0;
    int          m_miss    = 0;
    logic [31:0] m_pc      = 32'h0;

    // Observed/expected vectors: {inst_valid, sel[4:0], imem_req, flush, fetch_err}
    logic [8:0]  obs, exp_v;
    logic [31:0] obs_pc, exp_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RST_WAIT (RST_WAIT),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ack   (imem_ack),
        .stall      (stall),
        .br_taken   (br_taken),
        .jal        (jal),
        .jalr       (jalr),
        .imem_req   (imem_req),
        .inst_valid (inst_valid),
        .flush      (flush),
        .fetch_err  (fetch_err),
        .mux1       (mux1),
        .mux2       (mux2),
        .mux3       (mux3),
        .mux4       (mux4),
        .mux4_2     (mux4_2)
    );

    // PC datapath steered by the DUT selects.
    assign add_res = (mux4 ? 32'd4 : imm12) + (mux4_2 ? pc : reg_in);
    assign pc_next = mux2 ? pc : (mux3 ? imm20 : (mux1 ? add_res : brch));

    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else     pc <= pc_next;
    end

    function automatic logic [8:0] model_exp();
        logic [4:0] s;
        logic       iv;
        logic       fetching;
        s        = B_HOLD;
        iv       = 1'b0;
        fetching = !m_waiting && !m_bubble && !m_err;
        if (!rst && (fetching || m_bubble)) begin
            if (jalr)          s = B_JALR;
            else if (jal)      s = B_JAL;
            else if (br_taken) s = B_BR;
            else if (fetching && imem_ack) begin
                iv = 1'b1;
                s  = stall ? B_HOLD : B_SEQ;
            end
        end
        return {iv, s, fetching, m_bubble, m_err};
    endfunction

    task automatic model_advance();
        logic [31:0] target;
        logic        redir;
        redir  = jalr | jal | br_taken;
        target = jalr ? (reg_in + imm12) : (jal ? imm20 : brch);
        if (rst) begin
            m_waiting = 1'b1; m_elapsed = 0; m_bubble = 1'b0;
            m_err = 1'b0; m_miss = 0; m_pc = 32'h0;
        end else if (m_waiting) begin
            m_elapsed++;
            if (m_elapsed == int'(RST_WAIT)) m_waiting = 1'b0;
        end else if (m_err) begin
            m_miss = m_miss;
        end else if (m_bubble) begin
            if (redir) m_pc = target;
            else       m_bubble = 1'b0;
        end else if (redir) begin
            m_pc = target; m_bubble = 1'b1; m_miss = 0;
        end else if (imem_ack) begin
            m_miss = 0;
            if (!stall) m_pc = m_pc + 32'd4;
        end else begin
            m_miss++;
            if (m_miss == int'(TIMEOUT)) m_err = 1'b1;
        end
    endtask

    // One clock: drive, capture observed/expected at negedge, advance the model.
    task automatic tick(input bit r, input bit a, input bit s,
                        input bit b, input bit j, input bit jr);
        rst = r; imem_ack = a; stall = s; br_taken = b; jal = j; jalr = jr;
        @(negedge clk);
        exp_v  = model_exp();
        exp_pc = m_pc;
        obs    = {inst_valid, mux1, mux2, mux3, mux4, mux4_2, imem_req, flush, fetch_err};
        obs_pc = pc;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(RST_WAIT); i++) begin
            tick(0, 0, 0, 0, 0, 0);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_seq cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        tick(1, 1, 0, 1, 0, 0);
        tick(1, 1, 0, 0, 1, 0);
        total++;
        if (obs !== {1'b0, B_HOLD, 3'b000}) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", obs, {1'b0, B_HOLD, 3'b000});
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            total++;
            if (obs[2] !== (i == 2) || (i < 2 && (obs[6] !== 1'b1 || obs_pc !== 32'h0))) begin
                bad++;
                $display("FAIL reset_release cyc%0d: got req=%b mux2=%b pc=%h want req=%b",
                         i, obs[2], obs[6], obs_pc, (i == 2));
            end
        end
    endtask

    task automatic test_seq();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            total++;
            if (obs_pc !== 32'(4 * i) || obs !== {1'b1, B_SEQ, 3'b100}) begin
                bad++;
                $display("FAIL seq cyc%0d: got pc=%h v=%b want pc=%h v=%b",
                         i, obs_pc, obs, 32'(4 * i), {1'b1, B_SEQ, 3'b100});
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 1, 0, 0, 0);
            total++;
            if (obs_pc !== 32'd8 || obs[6] !== 1'b1 || obs !== exp_v) begin
                bad++;
                $display("FAIL stall cyc%0d: got pc=%h v=%b want pc=8 v=%b", i, obs_pc, obs, exp_v);
            end
        end
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        total++;
        if (obs_pc !== 32'd12) begin
            bad++;
            $display("FAIL stall_resume: got pc=%h want 0000000c", obs_pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        brch = 32'h100;
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        total++;
        if (obs[8:3] !== {1'b0, B_BR}) begin
            bad++;
            $display("FAIL br_sel: got %b want %b", obs[8:3], {1'b0, B_BR});
        end
        tick(0, 1, 0, 0, 0, 0);
        total++;
        if (obs[2:0] !== 3'b010 || obs_pc !== 32'h100 || obs[8] !== 1'b0) begin
            bad++;
            $display("FAIL br_bubble: got regs=%b pc=%h iv=%b want regs=010 pc=100 iv=0",
                     obs[2:0], obs_pc, obs[8]);
        end
        tick(0, 1, 0, 0, 0, 0);
        total++;
        if (obs[2:0] !== 3'b100 || obs_pc !== 32'h100 || obs[8] !== 1'b1) begin
            bad++;
            $display("FAIL br_refetch: got regs=%b pc=%h iv=%b want regs=100 pc=100 iv=1",
                     obs[2:0], obs_pc, obs[8]);
        end
    endtask

    task automatic test_jump_priority();
        do_reset();
        reg_in = 32'h200; imm12 = 32'h10; imm20 = 32'h4000; brch = 32'h900;
        tick(0, 1, 1, 1, 1, 1);
        total++;
        if (obs[7:3] !== B_JALR) begin
            bad++;
            $display("FAIL jalr_wins: got %b want %b", obs[7:3], B_JALR);
        end
        // Redirect arriving during the bubble extends it.
        tick(0, 0, 0, 0, 1, 0);
        total++;
        if (obs_pc !== 32'h210 || obs[7:3] !== B_JAL || obs[1] !== 1'b1) begin
            bad++;
            $display("FAIL bubble_jal: got pc=%h sel=%b flush=%b want pc=210 sel=%b flush=1",
                     obs_pc, obs[7:3], obs[1], B_JAL);
        end
        tick(0, 0, 0, 0, 0, 0);
        total++;
        if (obs_pc !== 32'h4000 || obs[2:0] !== 3'b010) begin
            bad++;
            $display("FAIL bubble_ext: got pc=%h regs=%b want pc=4000 regs=010", obs_pc, obs[2:0]);
        end
        tick(0, 1, 0, 0, 0, 0);
        total++;
        if (obs[2:0] !== 3'b100) begin
            bad++;
            $display("FAIL bubble_exit: got regs=%b want 100", obs[2:0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            tick(0, 0, 0, 0, 0, 0);
            total++;
            if (obs !== {1'b0, B_HOLD, 3'b100}) begin
                bad++;
                $display("FAIL timeout_wait cyc%0d: got %b want %b", i, obs, {1'b0, B_HOLD, 3'b100});
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, i == 1, 0, 0);
            total++;
            if (obs !== {1'b0, B_HOLD, 3'b001}) begin
                bad++;
                $display("FAIL timeout_err cyc%0d: got %b want %b", i, obs, {1'b0, B_HOLD, 3'b001});
            end
        end
    endtask

    task automatic test_rst_in_bubble();
        do_reset();
        tick(0, 1, 0, 1, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            total++;
            if (obs[2:0] !== ((i == 2) ? 3'b100 : 3'b000)) begin
                bad++;
                $display("FAIL rst_bubble cyc%0d: got regs=%b want %b",
                         i, obs[2:0], (i == 2) ? 3'b100 : 3'b000);
            end
        end
    endtask

    task automatic test_random();
        bit r, a, s, b, j, jr;
        for (int i = 0; i < 600; i++) begin
            brch   = $urandom; imm20 = $urandom;
            imm12  = $urandom; reg_in = $urandom;
            r  = ($urandom_range(0, 39) == 0);
            a  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 14) == 0);
            jr = ($urandom_range(0, 14) == 0);
            tick(r, a, s, b, j, jr);
            total++;
            if (obs !== exp_v || obs_pc !== exp_pc) begin
                bad++;
                $display("FAIL random cyc%0d: got v=%b pc=%h want v=%b pc=%h",
                         i, obs, obs_pc, exp_v, exp_pc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        br_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
        brch = 32'h0; imm20 = 32'h0; imm12 = 32'h0; reg_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_seq();
        test_stall();
        test_branch();
        test_jump_priority();
        test_timeout();
        test_rst_in_bubble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
